// File: rtl/atm_ledger_if.sv
// Request/response handshake bundle between the transaction controller and atm_ledger.
interface atm_ledger_if #(
    parameter int ACCT_W = 4,
    parameter int AMT_W  = 12,
    parameter int BAL_W  = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ACCT_W-1:0] req_acct;
    logic [ACCT_W-1:0] req_dst;
    logic [AMT_W-1:0]  req_amt;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_status;
    logic [BAL_W-1:0]  rsp_balance;

    modport master (
        output req_valid, req_op, req_acct, req_dst, req_amt, rsp_ready,
        input  req_ready, rsp_valid, rsp_status, rsp_balance
    );

    modport slave (
        input  req_valid, req_op, req_acct, req_dst, req_amt, rsp_ready,
        output req_ready, rsp_valid, rsp_status, rsp_balance
    );
endinterface

// File: rtl/atm_ledger.sv
// Multi-account balance ledger with per-account daily withdrawal limit.
// state | meaning
// IDLE  | waiting for a request, req_ready high
// EXEC  | request latched, checks and updates commit on the next edge
// RESP  | response held until rsp_ready
module atm_ledger #(
    parameter int BAL_W     = 16,
    parameter int AMT_W     = 12,
    parameter int N_ACCT    = 4,
    parameter int ACCT_W    = 4,
    parameter int DAY_LIMIT = 1000
) (
    input  logic         clk,
    input  logic         res_n,
    atm_ledger_if.slave  bus,
    input  logic         day_tick,
    output logic         max_bal,
    output logic         min_bal
);
    localparam int DAY_W = $clog2(DAY_LIMIT + 1);
    localparam logic [ACCT_W:0] N_ACCT_L = (ACCT_W + 1)'(N_ACCT);
    localparam logic [31:0] DAY_LIM_L = 32'(DAY_LIMIT);

    localparam logic [1:0] OP_DEP   = 2'b00;
    localparam logic [1:0] OP_WD    = 2'b01;
    localparam logic [1:0] OP_QUERY = 2'b10;
    localparam logic [1:0] OP_XFER  = 2'b11;

    localparam logic [2:0] ST_OK    = 3'd0;
    localparam logic [2:0] ST_OVF   = 3'd1;
    localparam logic [2:0] ST_UNF   = 3'd2;
    localparam logic [2:0] ST_LIMIT = 3'd3;
    localparam logic [2:0] ST_BAD   = 3'd4;
    localparam logic [2:0] ST_ZERO  = 3'd5;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state;
    logic [1:0]        op_q;
    logic [ACCT_W-1:0] acct_q;
    logic [ACCT_W-1:0] dst_q;
    logic [AMT_W-1:0]  amt_q;

    logic [BAL_W-1:0]  bal [N_ACCT];
    logic [DAY_W-1:0]  day [N_ACCT];

    logic              src_ok, dst_ok, bad, is_debit;
    logic [BAL_W-1:0]  src_bal, dst_bal, amt_ext, src_diff;
    logic [DAY_W-1:0]  day_used, day_new;
    logic [BAL_W:0]    src_sum, dst_sum;
    logic [31:0]       day_sum;
    logic [2:0]        status_c;
    logic [BAL_W-1:0]  rsp_bal_c;

    assign bus.req_ready = (state == IDLE);

    always_comb begin
        src_bal  = '0;
        dst_bal  = '0;
        day_used = '0;
        src_ok   = ({1'b0, acct_q} < N_ACCT_L);
        dst_ok   = ({1'b0, dst_q} < N_ACCT_L);
        for (int i = 0; i < N_ACCT; i++) begin
            if (acct_q == ACCT_W'(i)) begin
                src_bal  = bal[i];
                day_used = day[i];
            end
            if (dst_q == ACCT_W'(i)) dst_bal = bal[i];
        end
        // A day_tick coinciding with EXEC means the limit is checked against a fresh day.
        if (day_tick) day_used = '0;

        amt_ext  = BAL_W'(amt_q);
        src_sum  = {1'b0, src_bal} + {1'b0, amt_ext};
        dst_sum  = {1'b0, dst_bal} + {1'b0, amt_ext};
        src_diff = src_bal - amt_ext;
        day_sum  = 32'(day_used) + 32'(amt_q);
        day_new  = DAY_W'(day_sum);
        is_debit = (op_q == OP_WD) || (op_q == OP_XFER);
        bad      = !src_ok || ((op_q == OP_XFER) && (!dst_ok || (dst_q == acct_q)));

        if (bad)
            status_c = ST_BAD;
        else if ((op_q != OP_QUERY) && (amt_q == '0))
            status_c = ST_ZERO;
        else if (((op_q == OP_DEP) && src_sum[BAL_W]) || ((op_q == OP_XFER) && dst_sum[BAL_W]))
            status_c = ST_OVF;
        else if (is_debit && (amt_ext > src_bal))
            status_c = ST_UNF;
        else if (is_debit && (day_sum > DAY_LIM_L))
            status_c = ST_LIMIT;
        else
            status_c = ST_OK;

        rsp_bal_c = src_bal;
        if (status_c == ST_OK) begin
            if (op_q == OP_DEP)
                rsp_bal_c = src_sum[BAL_W-1:0];
            else if (is_debit)
                rsp_bal_c = src_diff;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state           <= IDLE;
            op_q            <= '0;
            acct_q          <= '0;
            dst_q           <= '0;
            amt_q           <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_status  <= '0;
            bus.rsp_balance <= '0;
            max_bal         <= 1'b0;
            min_bal         <= 1'b0;
            for (int i = 0; i < N_ACCT; i++) begin
                bal[i] <= '0;
                day[i] <= '0;
            end
        end else begin
            if (day_tick) begin
                for (int i = 0; i < N_ACCT; i++) day[i] <= '0;
            end
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q   <= bus.req_op;
                        acct_q <= bus.req_acct;
                        dst_q  <= bus.req_dst;
                        amt_q  <= bus.req_amt;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    state           <= RESP;
                    bus.rsp_valid   <= 1'b1;
                    bus.rsp_status  <= status_c;
                    bus.rsp_balance <= rsp_bal_c;
                    if (status_c == ST_OVF) max_bal <= 1'b1;
                    if (status_c == ST_UNF) min_bal <= 1'b1;
                    if ((status_c == ST_OK) && (op_q != OP_QUERY)) begin
                        max_bal <= 1'b0;
                        min_bal <= 1'b0;
                        for (int i = 0; i < N_ACCT; i++) begin
                            if (acct_q == ACCT_W'(i)) begin
                                if (op_q == OP_DEP) begin
                                    bal[i] <= src_sum[BAL_W-1:0];
                                end else begin
                                    bal[i] <= src_diff;
                                    day[i] <= day_new;
                                end
                            end
                            if ((op_q == OP_XFER) && (dst_q == ACCT_W'(i)))
                                bal[i] <= dst_sum[BAL_W-1:0];
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_atm_ledger.sv
// Scoreboard bench for atm_ledger: a behavioural ledger model predicts each response.
module tb_atm_ledger;
    localparam int NA   = 4;
    localparam int MAXB = 65535;
    localparam int LIM  = 1000;

    typedef struct {
        int st;
        int bal;
        bit mx;
        bit mn;
    } exp_t;

    logic clk = 1'b0;
    logic res_n = 1'b0;
    logic day_tick = 1'b0;
    logic max_bal, min_bal;

    atm_ledger_if #(.ACCT_W(4), .AMT_W(12), .BAL_W(16)) bus ();

    atm_ledger #(
        .BAL_W(16), .AMT_W(12), .N_ACCT(NA), .ACCT_W(4), .DAY_LIMIT(LIM)
    ) dut (
        .clk(clk),
        .res_n(res_n),
        .bus(bus),
        .day_tick(day_tick),
        .max_bal(max_bal),
        .min_bal(min_bal)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   m_bal [NA];
    int   m_day [NA];
    bit   m_mx, m_mn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NA; i++) begin
            m_bal[i] = 0;
            m_day[i] = 0;
        end
        m_mx = 0;
        m_mn = 0;
    endtask

    task automatic model(input int op, input int acct, input int dst, input int amt,
                         input bit tick, output exp_t e);
        int sb, db, du, st;
        bit bad;
        bad = (acct >= NA) || (op == 3 && (dst >= NA || dst == acct));
        sb  = (acct < NA) ? m_bal[acct] : 0;
        db  = (dst < NA) ? m_bal[dst] : 0;
        du  = (tick || acct >= NA) ? 0 : m_day[acct];
        if (bad) st = 4;
        else if (op != 2 && amt == 0) st = 5;
        else if (op == 0 && sb + amt > MAXB) st = 1;
        else if (op == 3 && db + amt > MAXB) st = 1;
        else if ((op == 1 || op == 3) && amt > sb) st = 2;
        else if ((op == 1 || op == 3) && du + amt > LIM) st = 3;
        else st = 0;
        if (tick) for (int i = 0; i < NA; i++) m_day[i] = 0;
        if (st == 0) begin
            case (op)
                0: m_bal[acct] += amt;
                1: begin m_bal[acct] -= amt; m_day[acct] = du + amt; end
                3: begin m_bal[acct] -= amt; m_bal[dst] += amt; m_day[acct] = du + amt; end
                default: ;
            endcase
            if (op != 2) begin m_mx = 0; m_mn = 0; end
        end
        if (st == 1) m_mx = 1;
        if (st == 2) m_mn = 1;
        e.st  = st;
        e.bal = (acct < NA) ? m_bal[acct] : 0;
        e.mx  = m_mx;
        e.mn  = m_mn;
    endtask

    task automatic drive_req(input int op, input int acct, input int dst, input int amt,
                             input bit tick);
        exp_t e;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'(op);
        bus.req_acct  = 4'(acct);
        bus.req_dst   = 4'(dst);
        bus.req_amt   = 12'(amt);
        chk("req_ready_idle", 32'(bus.req_ready), 1);
        model(op, acct, dst, amt, tick, e);
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("req_ready_exec", 32'(bus.req_ready), 0);
        chk("rsp_valid_exec", 32'(bus.rsp_valid), 0);
        if (tick) day_tick = 1'b1;
    endtask

    task automatic wait_and_compare(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (!bus.rsp_valid && n < 10) begin
            @(negedge clk);
            day_tick = 1'b0;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 1);
        e = q.pop_front();
        chk({tag, "_status"}, 32'(bus.rsp_status), 32'(e.st));
        chk({tag, "_balance"}, 32'(bus.rsp_balance), 32'(e.bal));
        chk({tag, "_max_bal"}, 32'(max_bal), 32'(e.mx));
        chk({tag, "_min_bal"}, 32'(min_bal), 32'(e.mn));
    endtask

    task automatic txn(input string tag, input int op, input int acct, input int dst,
                       input int amt, input bit tick, input int hold);
        logic [2:0]  st0;
        logic [15:0] bal0;
        drive_req(op, acct, dst, amt, tick);
        wait_and_compare(tag);
        st0  = bus.rsp_status;
        bal0 = bus.rsp_balance;
        for (int k = 0; k < hold; k++) begin
            bus.req_valid = 1'b1;
            bus.req_op    = 2'b00;
            bus.req_acct  = 4'd1;
            bus.req_amt   = 12'd77;
            @(negedge clk);
            chk("hold_valid", 32'(bus.rsp_valid), 1);
            chk("hold_status", 32'(bus.rsp_status), 32'(st0));
            chk("hold_balance", 32'(bus.rsp_balance), 32'(bal0));
            chk("hold_req_ready", 32'(bus.req_ready), 0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, "_rsp_done"}, 32'(bus.rsp_valid), 0);
        chk({tag, "_ready_back"}, 32'(bus.req_ready), 1);
    endtask

    task automatic tick_pulse();
        @(negedge clk);
        day_tick = 1'b1;
        @(negedge clk);
        day_tick = 1'b0;
        for (int i = 0; i < NA; i++) m_day[i] = 0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_acct  = '0;
        bus.req_dst   = '0;
        bus.req_amt   = '0;
        bus.rsp_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_max_bal", 32'(max_bal), 0);
        chk("rst_min_bal", 32'(min_bal), 0);
        chk("rst_balance", 32'(bus.rsp_balance), 0);
        res_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 1);

        // deposits and withdraw, account 0
        txn("dep500a", 0, 0, 0, 500, 0, 0);
        txn("dep500b", 0, 0, 0, 500, 0, 0);
        txn("wd1000", 1, 0, 0, 1000, 0, 0);

        // overflow on account 1
        for (int i = 0; i < 15; i++) txn("pre1", 0, 1, 0, 4095, 0, 0);
        txn("pre1_last", 0, 1, 0, 3575, 0, 0);
        txn("dep_ovf", 0, 1, 0, 600, 0, 0);
        txn("dep_max", 0, 1, 0, 535, 0, 0);

        // underflow, query, zero on account 2
        txn("pre2", 0, 2, 0, 100, 0, 0);
        txn("wd_unf", 1, 2, 0, 101, 0, 0);
        txn("query2", 2, 2, 0, 0, 0, 0);
        txn("wd_zero", 1, 2, 0, 0, 0, 0);
        txn("wd_all2", 1, 2, 0, 100, 0, 0);

        // daily limit on account 3
        txn("pre3", 0, 3, 0, 3000, 0, 0);
        txn("wd600", 1, 3, 0, 600, 0, 0);
        txn("wd_limit", 1, 3, 0, 500, 0, 0);
        tick_pulse();
        txn("wd_after_tick", 1, 3, 0, 500, 0, 0);
        txn("wd100", 1, 3, 0, 100, 0, 0);
        txn("wd900_tick", 1, 3, 0, 900, 1, 0);
        txn("wd_lim_again", 1, 3, 0, 101, 0, 0);

        // transfers
        txn("pre0", 0, 0, 0, 300, 0, 0);
        txn("xfer_ovf", 3, 0, 1, 1, 0, 0);
        txn("xfer_ok", 3, 1, 0, 35, 0, 0);
        txn("query0", 2, 0, 0, 0, 0, 0);
        txn("wd1_over", 1, 1, 0, 966, 0, 0);
        txn("wd1_edge", 1, 1, 0, 965, 0, 0);
        txn("xfer_self", 3, 2, 2, 5, 0, 0);
        txn("xfer_baddst", 3, 0, 9, 5, 0, 0);
        txn("bad_acct", 2, 7, 0, 0, 0, 0);
        txn("bad_acct_dep", 0, 7, 0, 10, 0, 0);

        // backpressure: held response, ignored request
        txn("bp_query", 2, 1, 0, 0, 0, 5);
        txn("bp_after", 2, 1, 0, 0, 0, 0);

        // reset while holding a response
        drive_req(0, 1, 0, 4095, 0);
        wait_and_compare("pre_rst");
        @(negedge clk);
        res_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(bus.rsp_valid), 0);
        chk("rst_mid_status", 32'(bus.rsp_status), 0);
        chk("rst_mid_balance", 32'(bus.rsp_balance), 0);
        chk("rst_mid_max", 32'(max_bal), 0);
        chk("rst_mid_min", 32'(min_bal), 0);
        model_reset();
        @(negedge clk);
        res_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", 32'(bus.req_ready), 1);
        for (int a = 0; a < NA; a++) txn("post_rst_query", 2, a, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/atm_ledger.md
# atm_ledger

- Multi-account, parametrised successor to the single-account ATM balance register.
- Holds `N_ACCT` account balances and a per-account daily withdrawal counter.
- Executes deposit, withdraw, query and transfer requests through a valid/ready request port and a valid/ready response port.
- Reports per-transaction status codes, and sticky max/min LED flags on overflow/underflow rejects.
- Sits between the keypad/transaction controller and the display/LED driver.

## Interface
Parameters:
- `BAL_W`, 16: balance width in bits; max balance is 2^BAL_W-1.
- `AMT_W`, 12: request amount width (AMT_W <= BAL_W).
- `N_ACCT`, 4: number of accounts (2..16).
- `ACCT_W`, 4: account index width.
- `DAY_LIMIT`, 1000: maximum total withdrawn per account per day (transfers out count).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `res_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: ledger can accept a request.
- `req_op` in 2: 00 deposit, 01 withdraw, 10 query, 11 transfer.
- `req_acct` in ACCT_W: source/target account.
- `req_dst` in ACCT_W: destination account (transfer only).
- `req_amt` in AMT_W: amount.
- `rsp_valid` out 1: response held until accepted.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_status` out 3: 0 OK, 1 OVERFLOW, 2 UNDERFLOW, 3 LIMIT, 4 BADACCT, 5 ZERO.
- `rsp_balance` out BAL_W: `req_acct` balance after the operation.
- `day_tick` in 1: one-cycle pulse that clears all daily counters.
- `max_bal` out 1: sticky overflow LED.
- `min_bal` out 1: sticky underflow LED.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
  - `req_ready` = (state==IDLE).
  - IDLE→EXEC on `req_valid && req_ready`; op/acct/dst/amt are latched.
  - EXEC→RESP unconditionally; checks, updates and response registers are all committed on this edge.
  - RESP→IDLE on `rsp_valid && rsp_ready`.
- Checks are evaluated in priority order; the first failure wins and changes no balance or counter:
  1. BADACCT: `req_acct` >= N_ACCT; for a transfer, also `req_dst` >= N_ACCT or `req_dst` == `req_acct`.
  2. ZERO: amount == 0, for any op except query.
  3. OVERFLOW:
     - deposit: bal + amt > 2^BAL_W-1, computed BAL_W+1 wide.
     - transfer: dst bal + amt > 2^BAL_W-1.
  4. UNDERFLOW: withdraw/transfer with amt > src bal. amt == bal is legal and leaves a balance of 0.
  5. LIMIT: withdraw/transfer with daily[src] + amt > DAY_LIMIT.
- Success effects:
  - deposit: bal += amt.
  - withdraw: bal -= amt; daily += amt.
  - transfer: src -= amt and dst += amt atomically on the same edge; daily[src] += amt.
  - query: no state change; status OK.
- Daily counters are width ceil(log2(DAY_LIMIT+1)) and never exceed DAY_LIMIT.
- `day_tick`:
  - In any state, clears all daily counters on the next edge.
  - If it is high during EXEC, the limit check uses 0, and the counter ends at amt (success) or 0 (reject).
- LED flags, updated at the EXEC→RESP edge:
  - OVERFLOW reject: `max_bal`←1, `min_bal` unchanged.
  - UNDERFLOW reject: `min_bal`←1, `max_bal` unchanged.
  - Any successful deposit/withdraw/transfer: both flags ←0.
  - Query, LIMIT, BADACCT, ZERO: flags hold.
- `rsp_balance` is the `req_acct` balance after the operation. It is 0 for BADACCT when `req_acct` is out of range.

## Timing
- Reset values (`res_n` low, asynchronous):
  - state IDLE, so `req_ready`=1 after release.
  - All balances, daily counters, `rsp_valid`, `rsp_status`, `rsp_balance`, `max_bal` and `min_bal` are 0.
- Reset asserted mid-operation (EXEC or RESP) aborts the transaction immediately. The pending response is lost and no partial transfer remains.
- Latency: request accepted at edge E0 → balances updated and `rsp_valid`=1 at edge E1.
- Throughput: one transaction per 3 cycles when `rsp_ready` is tied high.
- `rsp_*` outputs are stable while `rsp_valid`=1 and `rsp_ready`=0.
- Request inputs are ignored outside IDLE.
- `req_ready` drops at E0 and returns on the edge that completes the response handshake.

## Test plan
- Deposits and withdrawal on acct 0 (BAL_W=16):
  - Deposit 500, then 500 → OK, balance 1000; `rsp_valid` exactly one cycle after acceptance.
  - Withdraw 1000 → OK, balance 0, `min_bal`=0.
- Overflow:
  - Preload acct 1 to 65000 via deposits; deposit 600 → OVERFLOW, balance stays 65000, `max_bal`=1.
  - Deposit 535 → OK, balance 65535, `max_bal`=0.
- Underflow and zero amount:
  - Acct 2 = 100; withdraw 101 → UNDERFLOW, `min_bal`=1, balance 100.
  - Query → OK, `min_bal` still 1.
  - Withdraw 0 → ZERO.
- Daily limit (DAY_LIMIT=1000):
  - Acct 3 = 3000; withdraw 600 → OK; withdraw 500 → LIMIT, balance 2400.
  - Pulse `day_tick`, withdraw 500 → OK, balance 1900.
  - Separately, assert `day_tick` during EXEC of withdraw 900 with daily=600 → OK.
- Transfer:
  - Acct 0=300, acct 1=65535; transfer 0→1 amt 1 → OVERFLOW, both unchanged.
  - Transfer 1→0 amt 35 → OK: acct 1=65500, acct 0=335, daily[1]=35.
  - Transfer 2→2 → BADACCT.
  - `req_acct`=7 with N_ACCT=4 → BADACCT, `rsp_balance`=0.
- Backpressure and reset:
  - Hold `rsp_ready`=0 for 5 cycles: `rsp_*` stable, `req_ready`=0, a new `req_valid` is ignored.
  - Assert `res_n`=0 during RESP: all outputs 0 immediately; after release `req_ready`=1 and balances are 0.
